seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared hex_to_7seg decoder across NUM_DIGITS common-anode 7-segment digits.
- Holds a display register and selects one nibble per slot, presented on hex_out.
- Registers the decoder's returned pattern and drives segment and digit-enable lines, with dead time between digits to prevent ghosting.
- New values are accepted via a load handshake and applied only at frame boundaries, so a frame never tears.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 2, dead-time cycles at the start of each slot (≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant
- load  input  1  request to capture data_in
- load_ack  output  1  one-cycle pulse when captured data becomes displayed
- hex_out  output  4  nibble to shared decoder input
- seg_in  input  7  active-low pattern returned by decoder (combinational path)
- seg_out  output  7  active-low segments {g..a} to display
- dig_n  output  NUM_DIGITS  active-low digit enables; at most one bit low
- frame_tick  output  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Reset (async, rst_n=0):
  - dig_n all 1; seg_out=7'h7F; hex_out=0; load_ack=0; frame_tick=0.
  - Display register=0, shadow=0, pending=0, digit index=0, slot counter=0, state DEAD.
- Slot counter counts 0..DIV-1 and wraps.
- At wrap, the index advances (NUM_DIGITS-1 wraps to 0) and the state returns to DEAD.
- DEAD (counter 0..BLANK_CYCLES-1):
  - dig_n all 1, seg_out=7'h7F.
  - hex_out is registered to the current index's nibble on the first DEAD cycle.
- Transition at counter==BLANK_CYCLES-1 -> ON: seg_out <= seg_in (or 7'h7F if digit blanked), registered.
- ON (counter BLANK_CYCLES..DIV-1):
  - dig_n[index]=0, all other bits 1; seg_out is held.
  - Segments are therefore stable at least one cycle before any enable goes low.
- Load handshake:
  - load=1 on any cycle copies data_in into the shadow register and sets pending.
  - A later load before apply overwrites the shadow (last value wins).
- Apply:
  - On the cycle the slot counter wraps while index==NUM_DIGITS-1, frame_tick=1.
  - If pending: display <= shadow, pending cleared, load_ack=1 in that same cycle.
- Simultaneous load and apply in the same cycle:
  - The current shadow is applied.
  - The new data_in goes to the shadow and pending stays set for the next frame.
- Latency: load to load_ack is at most NUM_DIGITS*DIV cycles. The first digit of the new frame shows the new value.
- Reset mid-slot forces all outputs to the reset values immediately (async). Scanning restarts at digit 0, DEAD.
- hex_out changes only in DEAD, so the decoder input never changes while a digit is enabled.
- Output widths are fixed. The counter is $clog2(DIV) bits and the index $clog2(NUM_DIGITS) bits, minimum 1.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined:
  - Any digit k>0 whose nibble and all higher nibbles are 0 is blanked: seg_out=7'h7F during its ON phase, dig_n is still asserted.
  - The blank mask is computed from the display register, not the shadow.
  - Digit 0 is never blanked, so 0x0000 shows a single "0".
- Undefined: all digits are always shown, including leading zeros. No extra logic is synthesised.

Test Plan:
- Reset, NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2, no load -> dig_n sequence 1110,1101,1011,0111 with 6 low cycles each; hex_out=0; seg_out=7'h40 during ON; frame_tick every 32 cycles.
- load with data_in=16'h12AF mid-frame -> load_ack and frame_tick coincide at the frame end; next frame hex_out=F,A,2,1 and seg_out=0E,08,24,79 during ON.
- Two loads, 16'h1111 then 16'h2222, within one frame -> a single load_ack; displayed value is 2222; 1111 is never shown.
- load asserted exactly on the frame_tick cycle -> old shadow applied now; new value applied and acked at the next frame_tick.
- Glitch check every cycle -> never more than one dig_n bit low; dig_n all 1 whenever hex_out changes; seg_out constant while any dig_n bit is low.
- With LEAD_ZERO_BLANK_EN, load 16'h0050 -> digits 3,2 show 7F, digits 1,0 show 12,40. Load 16'h0000 -> only digit 0 shows 40. rst_n pulse mid-ON -> dig_n=1111 and seg_out=7F asynchronously.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes one shared hex_to_7seg decoder across NUM_DIGITS common-anode digits with dead time and tear-free frame updates.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [3:0]              hex_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_tick
);
  localparam int CW = DIV > 2 ? $clog2(DIV) : 1;
  localparam int IW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4*NUM_DIGITS;
  typedef enum logic {DEAD, ON} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   disp_q, disp_d, shad_q, shad_d;
  logic            pend_q, pend_d;
  logic [3:0]      hex_q, hex_d;
  logic [6:0]      seg_q, seg_d;
  logic            wrap, last, apply, blank_cur;
  assign wrap  = cnt_q == CW'(DIV-1);
  assign last  = idx_q == IW'(NUM_DIGITS-1);
  assign apply = wrap & last;
`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  hi_zero;
  // blank[k] is set when nibble k and every nibble above it are zero
  always_comb begin
    hi_zero = 1'b1;
    blank   = '0;
    for (int k = NUM_DIGITS-1; k > 0; k--) begin
      hi_zero  = hi_zero & (disp_q[4*k +: 4] == 4'h0);
      blank[k] = hi_zero;
    end
  end
  assign blank_cur = blank[idx_q];
`else
  assign blank_cur = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    hex_d   = hex_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? (last ? '0 : idx_q + 1'b1) : idx_q;
    disp_d  = apply && pend_q ? shad_q : disp_q;
    shad_d  = load ? data_in : shad_q;
    pend_d  = load | (pend_q & ~apply);
    if (wrap) begin
      state_d = DEAD;
      seg_d   = 7'h7F;
      hex_d   = disp_d[4*idx_d +: 4];
    end else if (state_q == DEAD && cnt_q == CW'(BLANK_CYCLES-1)) begin
      state_d = ON;
      seg_d   = blank_cur ? 7'h7F : seg_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      shad_q  <= '0;
      pend_q  <= 1'b0;
      hex_q   <= '0;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
      hex_q   <= hex_d;
      seg_q   <= seg_d;
    end
  end
  assign hex_out    = hex_q;
  assign seg_out    = seg_q;
  assign dig_n      = state_q == ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  assign frame_tick = apply;
  assign load_ack   = apply & pend_q;
endmodule
